mem_pipe_sequencer: RTL and testbench

//  Sequential, parametrised control unit for the two-stage (FE/EC) pipeline with one shared memory bus.

---
 rtl/mem_pipe_sequencer_pkg.sv | 27 ++
 rtl/mem_pipe_sequencer_perf.sv | 31 +++
 rtl/mem_pipe_sequencer.sv | 195 +++++++++++++++++++
 tb/tb_mem_pipe_sequencer.sv | 387 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pipe_sequencer_pkg.sv
// Shared types for the FE/EC memory-bus sequencer: FSM states, bus-owner
// decode and a saturating increment used by the optional perf counters.
package mem_pipe_sequencer_pkg;

   typedef enum logic [1:0] {
      SEQ_IDLE,
      SEQ_RUN,
      SEQ_HOLD,
      SEQ_HALTED
   } seq_state_t;

   // Which requester owns the bus in a RUN cycle, highest priority first.
   typedef enum logic [1:0] {
      BUS_COMMIT,
      BUS_EXMEM,
      BUS_BRANCH,
      BUS_FETCH
   } bus_owner_t;

   // Opcode of the HALT instruction as seen on the read bus / commit stage.
   localparam logic [3:0] OP_HALT = 4'hF;

   function automatic logic [31:0] sat_inc32(input logic [31:0] val);
      return (val == '1) ? val : val + 32'd1;
   endfunction

endpackage

// File: rtl/mem_pipe_sequencer_perf.sv
// Two saturating 32-bit event counters (stall cycles, memory operations).
// Only instantiated when MEM_SEQ_PERF_EN is defined.
module mem_seq_perf_counters
   import mem_pipe_sequencer_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        stall_i,
   input  logic        mem_op_i,
   output logic [31:0] stall_cycles_o,
   output logic [31:0] mem_ops_o
);

   logic [31:0] stall_q;
   logic [31:0] ops_q;

   // Count events, holding at all-ones instead of wrapping.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_q <= '0;
         ops_q   <= '0;
      end else begin
         if (stall_i)  stall_q <= sat_inc32(stall_q);
         if (mem_op_i) ops_q   <= sat_inc32(ops_q);
      end
   end

   assign stall_cycles_o = stall_q;
   assign mem_ops_o      = ops_q;

endmodule

// File: rtl/mem_pipe_sequencer.sv
// Bus arbiter and stage-enable sequencer for the FE/EC pipeline sharing one
// memory bus. Optional build macro: MEM_SEQ_PERF_EN (stall / mem-op counters;
// without it stall_cycles and mem_ops are tied to 0).
//
// state      | meaning
// SEQ_IDLE   | one quiet cycle after reset, bus parked in read mode
// SEQ_RUN    | normal arbitration: commit store > EX load/store > branch > fetch
// SEQ_HOLD   | multi-cycle access, latched bus/rw/write_commit, pipeline frozen
// SEQ_HALTED | HALT committed; sticky until rst_n
module mem_pipe_sequencer
   import mem_pipe_sequencer_pkg::*;
#(
   parameter int unsigned ADDR_W      = 10,
   parameter int unsigned DATA_W      = 6,
   parameter int unsigned WAIT_CYCLES = 0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [ADDR_W-1:0] pc,
   input  logic [ADDR_W-1:0] mem_address,
   input  logic [DATA_W-1:0] mem_write_data,
   input  logic              mem_load,
   input  logic              mem_store,
   input  logic              mem_store_commit,
   input  logic              store_upper,
   input  logic              branch_ex,
   input  logic              halt_fetch,
   input  logic              halt_commit,
   output logic              pc_enable,
   output logic              fe_reg_enable,
   output logic              fe_reg_clear,
   output logic              ec_reg_enable,
   output logic              ec_reg_clear,
   output logic              write_commit,
   output logic              mem_read_write,
   output logic [ADDR_W-1:0] mem_bus_out,
   output logic              halted,
   output logic [31:0]       stall_cycles,
   output logic [31:0]       mem_ops
);

   localparam int unsigned CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
   localparam logic [CNT_W-1:0] WAIT_LOAD =
      CNT_W'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

   seq_state_t         state_q, state_d;
   logic [CNT_W-1:0]   wait_cnt_q, wait_cnt_d;
   logic [ADDR_W-1:0]  hold_bus_q, hold_bus_d;
   logic               hold_rw_q, hold_rw_d;
   logic               hold_wc_q, hold_wc_d;

   bus_owner_t         owner;
   logic [ADDR_W-1:0]  run_bus;
   logic               run_rw;
   logic               run_wc;
   logic               run_pc_en, run_fe_en, run_fe_clr, run_ec_en, run_ec_clr;

   // RUN-cycle bus owner and the strobes that owner implies.
   always_comb begin
      owner      = BUS_FETCH;
      run_bus    = pc;
      run_rw     = 1'b1;
      run_wc     = 1'b0;
      run_pc_en  = 1'b0;
      run_fe_en  = 1'b0;
      run_fe_clr = 1'b0;
      run_ec_en  = 1'b0;
      run_ec_clr = 1'b0;
      if (mem_store_commit) begin
         owner                = BUS_COMMIT;
         run_bus              = '0;
         run_bus[DATA_W-1:0]  = mem_write_data;
         run_bus[DATA_W]      = store_upper;
         run_rw               = 1'b0;
         run_wc               = 1'b1;
         run_ec_clr           = 1'b1;
      end else if (mem_load || mem_store) begin
         owner      = BUS_EXMEM;
         run_bus    = mem_address;
         run_rw     = ~mem_store;
         run_fe_clr = 1'b1;
         run_ec_en  = 1'b1;
      end else if (branch_ex) begin
         owner      = BUS_BRANCH;
         run_fe_clr = 1'b1;
         run_ec_en  = 1'b1;
      end else begin
         run_fe_en  = 1'b1;
         run_ec_en  = 1'b1;
         run_pc_en  = ~halt_fetch;
      end
      // A committing HALT parks the bus in read mode and flags it.
      if (halt_commit) begin
         run_rw = 1'b1;
         run_wc = 1'b1;
      end
   end

   // Next-state logic and state-dependent output drive.
   always_comb begin
      state_d        = state_q;
      wait_cnt_d     = wait_cnt_q;
      hold_bus_d     = hold_bus_q;
      hold_rw_d      = hold_rw_q;
      hold_wc_d      = hold_wc_q;
      pc_enable      = 1'b0;
      fe_reg_enable  = 1'b0;
      fe_reg_clear   = 1'b0;
      ec_reg_enable  = 1'b0;
      ec_reg_clear   = 1'b0;
      write_commit   = 1'b0;
      mem_read_write = 1'b1;
      mem_bus_out    = '0;
      halted         = 1'b0;
      unique case (state_q)
         SEQ_IDLE: begin
            state_d = SEQ_RUN;
         end
         SEQ_RUN: begin
            pc_enable      = run_pc_en;
            fe_reg_enable  = run_fe_en;
            fe_reg_clear   = run_fe_clr;
            ec_reg_enable  = run_ec_en;
            ec_reg_clear   = run_ec_clr;
            write_commit   = run_wc;
            mem_read_write = run_rw;
            mem_bus_out    = run_bus;
            if (halt_commit) begin
               state_d = SEQ_HALTED;
            end else if ((WAIT_CYCLES > 0) && (owner != BUS_BRANCH)) begin
               state_d    = SEQ_HOLD;
               wait_cnt_d = WAIT_LOAD;
               hold_bus_d = run_bus;
               hold_rw_d  = run_rw;
               hold_wc_d  = run_wc;
            end
         end
         SEQ_HOLD: begin
            write_commit   = hold_wc_q;
            mem_read_write = hold_rw_q;
            mem_bus_out    = hold_bus_q;
            if (wait_cnt_q == '0) state_d = SEQ_RUN;
            else                  wait_cnt_d = wait_cnt_q - CNT_W'(1);
         end
         SEQ_HALTED: begin
            write_commit = 1'b1;
            halted       = 1'b1;
         end
         default: state_d = SEQ_IDLE;
      endcase
   end

   // State, wait counter and latched access registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= SEQ_IDLE;
         wait_cnt_q <= '0;
         hold_bus_q <= '0;
         hold_rw_q  <= 1'b0;
         hold_wc_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         wait_cnt_q <= wait_cnt_d;
         hold_bus_q <= hold_bus_d;
         hold_rw_q  <= hold_rw_d;
         hold_wc_q  <= hold_wc_d;
      end
   end

`ifdef MEM_SEQ_PERF_EN
   logic stall_evt;
   logic mem_op_evt;

   // A stall is any active-pipeline cycle where the PC does not advance;
   // a mem op is a RUN cycle that hands the bus to a load, store or commit store.
   always_comb begin
      stall_evt  = ((state_q == SEQ_RUN) || (state_q == SEQ_HOLD)) && !pc_enable;
      mem_op_evt = (state_q == SEQ_RUN) && !halt_commit &&
                   ((owner == BUS_COMMIT) || (owner == BUS_EXMEM));
   end

   mem_seq_perf_counters u_perf (
      .clk            (clk),
      .rst_n          (rst_n),
      .stall_i        (stall_evt),
      .mem_op_i       (mem_op_evt),
      .stall_cycles_o (stall_cycles),
      .mem_ops_o      (mem_ops)
   );
`else
   assign stall_cycles = '0;
   assign mem_ops      = '0;
`endif

endmodule

// File: tb/tb_mem_pipe_sequencer.sv
// Bench for mem_pipe_sequencer: directed scenarios plus a randomized run
// against a bus-ownership reference model. Two instances: single-cycle
// (WAIT_CYCLES=0) and multi-cycle (WAIT_CYCLES=2), sharing stimulus.
module tb_mem_pipe_sequencer;

   typedef struct packed {
      logic       pc_en;
      logic       fe_en;
      logic       fe_clr;
      logic       ec_en;
      logic       ec_clr;
      logic       wc;
      logic       rw;
      logic       halted;
      logic [9:0] bus;
   } obs_t;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [9:0] pc = '0;
   logic [9:0] mem_address = '0;
   logic [5:0] mem_write_data = '0;
   logic       mem_load = 0, mem_store = 0, mem_store_commit = 0, store_upper = 0;
   logic       branch_ex = 0, halt_fetch = 0, halt_commit = 0;

   logic       d0_pc_en, d0_fe_en, d0_fe_clr, d0_ec_en, d0_ec_clr, d0_wc, d0_rw, d0_halted;
   logic [9:0] d0_bus;
   logic [31:0] d0_stall, d0_ops;
   logic       d1_pc_en, d1_fe_en, d1_fe_clr, d1_ec_en, d1_ec_clr, d1_wc, d1_rw, d1_halted;
   logic [9:0] d1_bus;
   logic [31:0] d1_stall, d1_ops;

   int checks = 0;
   int errors = 0;

   // reference model state: phase 0 idle, 1 active, 2 halted
   int          m_phase [2];
   int          m_busy  [2];
   logic [9:0]  m_hbus  [2];
   logic        m_hrw   [2];
   logic        m_hwc   [2];
   logic [31:0] m_stall [2];
   logic [31:0] m_ops   [2];

   always #5 clk = ~clk;

   mem_pipe_sequencer #(.ADDR_W(10), .DATA_W(6), .WAIT_CYCLES(0)) u_dut0 (
      .clk(clk), .rst_n(rst_n), .pc(pc), .mem_address(mem_address),
      .mem_write_data(mem_write_data), .mem_load(mem_load), .mem_store(mem_store),
      .mem_store_commit(mem_store_commit), .store_upper(store_upper),
      .branch_ex(branch_ex), .halt_fetch(halt_fetch), .halt_commit(halt_commit),
      .pc_enable(d0_pc_en), .fe_reg_enable(d0_fe_en), .fe_reg_clear(d0_fe_clr),
      .ec_reg_enable(d0_ec_en), .ec_reg_clear(d0_ec_clr), .write_commit(d0_wc),
      .mem_read_write(d0_rw), .mem_bus_out(d0_bus), .halted(d0_halted),
      .stall_cycles(d0_stall), .mem_ops(d0_ops)
   );

   mem_pipe_sequencer #(.ADDR_W(10), .DATA_W(6), .WAIT_CYCLES(2)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .pc(pc), .mem_address(mem_address),
      .mem_write_data(mem_write_data), .mem_load(mem_load), .mem_store(mem_store),
      .mem_store_commit(mem_store_commit), .store_upper(store_upper),
      .branch_ex(branch_ex), .halt_fetch(halt_fetch), .halt_commit(halt_commit),
      .pc_enable(d1_pc_en), .fe_reg_enable(d1_fe_en), .fe_reg_clear(d1_fe_clr),
      .ec_reg_enable(d1_ec_en), .ec_reg_clear(d1_ec_clr), .write_commit(d1_wc),
      .mem_read_write(d1_rw), .mem_bus_out(d1_bus), .halted(d1_halted),
      .stall_cycles(d1_stall), .mem_ops(d1_ops)
   );

   function automatic obs_t get_obs(int i);
      if (i == 0)
         return {d0_pc_en, d0_fe_en, d0_fe_clr, d0_ec_en, d0_ec_clr, d0_wc, d0_rw, d0_halted, d0_bus};
      return {d1_pc_en, d1_fe_en, d1_fe_clr, d1_ec_en, d1_ec_clr, d1_wc, d1_rw, d1_halted, d1_bus};
   endfunction

   // Expected outputs from who owns the bus this cycle.
   function automatic obs_t model_out(int i);
      obs_t e;
      e    = '0;
      e.rw = 1'b1;
      if (m_phase[i] == 0) return e;
      if (m_phase[i] == 2) begin
         e.wc = 1'b1; e.halted = 1'b1;
         return e;
      end
      if (m_busy[i] > 0) begin
         e.bus = m_hbus[i]; e.rw = m_hrw[i]; e.wc = m_hwc[i];
         return e;
      end
      if (mem_store_commit) begin
         e.rw = 1'b0; e.bus = {3'b000, store_upper, mem_write_data}; e.wc = 1'b1; e.ec_clr = 1'b1;
      end else if (mem_load || mem_store) begin
         e.rw = ~mem_store; e.bus = mem_address; e.fe_clr = 1'b1; e.ec_en = 1'b1;
      end else if (branch_ex) begin
         e.bus = pc; e.fe_clr = 1'b1; e.ec_en = 1'b1;
      end else begin
         e.bus = pc; e.fe_en = 1'b1; e.ec_en = 1'b1; e.pc_en = ~halt_fetch;
      end
      if (halt_commit) begin
         e.rw = 1'b1; e.wc = 1'b1;
      end
      return e;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 2; i++) begin
         m_phase[i] = 1; m_busy[i] = 0; m_hbus[i] = '0; m_hrw[i] = 0; m_hwc[i] = 0;
         m_stall[i] = '0; m_ops[i] = '0;
      end
   endtask

   // Advance the model across one rising edge using the current inputs.
   task automatic model_step(int i, int waitc);
      obs_t e;
      e = model_out(i);
      if (m_phase[i] == 1 && !e.pc_en && m_stall[i] != '1) m_stall[i]++;
      if (m_phase[i] == 0) m_phase[i] = 1;
      else if (m_phase[i] == 1) begin
         if (m_busy[i] > 0) m_busy[i]--;
         else if (halt_commit) m_phase[i] = 2;
         else begin
            if ((mem_store_commit || mem_load || mem_store) && m_ops[i] != '1) m_ops[i]++;
            if (waitc > 0 && (mem_store_commit || mem_load || mem_store || !branch_ex)) begin
               m_busy[i] = waitc; m_hbus[i] = e.bus; m_hrw[i] = e.rw; m_hwc[i] = e.wc;
            end
         end
      end
   endtask

   task automatic clear_inputs();
      pc = '0; mem_address = '0; mem_write_data = '0;
      mem_load = 0; mem_store = 0; mem_store_commit = 0; store_upper = 0;
      branch_ex = 0; halt_fetch = 0; halt_commit = 0;
   endtask

   // Ends #1 after the edge that moves IDLE -> RUN.
   task automatic do_reset();
      rst_n = 1'b0;
      clear_inputs();
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      obs_t idle_v;
      idle_v = '0; idle_v.rw = 1'b1;
      rst_n = 1'b0;
      pc = 10'h3FF; mem_store_commit = 1; mem_write_data = 6'h15; halt_commit = 1;
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
         checks++;
         if (get_obs(i) !== idle_v) begin
            errors++; $display("FAIL reset_outputs dut%0d got %h expected %h", i, get_obs(i), idle_v);
         end
      end
      checks++;
      if (d0_stall !== 32'd0 || d0_ops !== 32'd0 || d1_stall !== 32'd0 || d1_ops !== 32'd0) begin
         errors++; $display("FAIL reset_perf got %0d %0d %0d %0d expected 0", d0_stall, d0_ops, d1_stall, d1_ops);
      end
      @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
         checks++;
         if (get_obs(i) !== idle_v) begin
            errors++; $display("FAIL idle_cycle dut%0d got %h expected %h", i, get_obs(i), idle_v);
         end
      end
      clear_inputs();
   endtask

   task automatic test_fetch();
      obs_t exp_v;
      do_reset();
      pc = 10'h015;
      exp_v = {1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 10'h015};
      @(negedge clk);
      checks++;
      if (get_obs(0) !== exp_v) begin
         errors++; $display("FAIL fetch got %h expected %h", get_obs(0), exp_v);
      end
      halt_fetch = 1;
      exp_v.pc_en = 1'b0;
      #1;
      checks++;
      if (get_obs(0) !== exp_v) begin
         errors++; $display("FAIL fetch_halt_word got %h expected %h", get_obs(0), exp_v);
      end
   endtask

   task automatic test_store_commit();
      obs_t exp_v;
      do_reset();
      pc = 10'h015; mem_store_commit = 1; mem_write_data = 6'h2A; store_upper = 1;
      exp_v = {1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 10'h06A};
      @(negedge clk);
      checks++;
      if (get_obs(0) !== exp_v) begin
         errors++; $display("FAIL store_commit got %h expected %h", get_obs(0), exp_v);
      end
   endtask

   task automatic test_commit_vs_load();
      obs_t exp_v;
      do_reset();
      pc = 10'h040; mem_store_commit = 1; mem_write_data = 6'h11; mem_load = 1; mem_address = 10'h123;
      exp_v = {1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 10'h011};
      @(negedge clk);
      checks++;
      if (get_obs(0) !== exp_v) begin
         errors++; $display("FAIL commit_wins got %h expected %h", get_obs(0), exp_v);
      end
      @(posedge clk);
      #1 mem_store_commit = 0;
      exp_v = {1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 10'h123};
      @(negedge clk);
      checks++;
      if (get_obs(0) !== exp_v) begin
         errors++; $display("FAIL load_retry got %h expected %h", get_obs(0), exp_v);
      end
   endtask

   task automatic test_load_wait();
      obs_t exp_v;
      do_reset();
      pc = 10'h100; mem_load = 1; mem_address = 10'h3F0;
      exp_v = {1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 10'h3F0};
      @(negedge clk);
      checks++;
      if (get_obs(1) !== exp_v) begin
         errors++; $display("FAIL load_wait_first got %h expected %h", get_obs(1), exp_v);
      end
      exp_v = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 10'h3F0};
      for (int k = 0; k < 2; k++) begin
         @(posedge clk);
         #1 mem_load = 0; mem_address = 10'h001;
         @(negedge clk);
         checks++;
         if (get_obs(1) !== exp_v) begin
            errors++; $display("FAIL load_wait_hold%0d got %h expected %h", k, get_obs(1), exp_v);
         end
      end
      @(posedge clk);
      #1;
      exp_v = {1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 10'h100};
      @(negedge clk);
      checks++;
      if (get_obs(1) !== exp_v) begin
         errors++; $display("FAIL load_wait_refetch got %h expected %h", get_obs(1), exp_v);
      end
   endtask

   task automatic test_halt();
      obs_t exp_v;
      do_reset();
      pc = 10'h055; halt_commit = 1;
      @(negedge clk);
      checks++;
      if (d0_rw !== 1'b1 || d0_wc !== 1'b1 || d0_halted !== 1'b0) begin
         errors++; $display("FAIL halt_commit got rw=%b wc=%b halted=%b expected 1 1 0", d0_rw, d0_wc, d0_halted);
      end
      @(posedge clk);
      #1 halt_commit = 0;
      exp_v = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 10'h000};
      for (int k = 0; k < 20; k++) begin
         pc = 10'($urandom); mem_load = 1'($urandom); mem_store_commit = 1'($urandom);
         @(negedge clk);
         checks++;
         if (get_obs(0) !== exp_v) begin
            errors++; $display("FAIL halted_sticky cycle%0d got %h expected %h", k, get_obs(0), exp_v);
         end
         @(posedge clk);
         #1;
      end
      clear_inputs();
      pc = 10'h077;
      #1 rst_n = 1'b0;
      #1;
      exp_v = '0; exp_v.rw = 1'b1;
      checks++;
      if (get_obs(0) !== exp_v) begin
         errors++; $display("FAIL halt_reset_async got %h expected %h", get_obs(0), exp_v);
      end
      @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      checks++;
      if (get_obs(0) !== exp_v) begin
         errors++; $display("FAIL halt_reset_idle got %h expected %h", get_obs(0), exp_v);
      end
      @(negedge clk);
      exp_v = {1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 10'h077};
      checks++;
      if (get_obs(0) !== exp_v) begin
         errors++; $display("FAIL halt_reset_run got %h expected %h", get_obs(0), exp_v);
      end
   endtask

   task automatic test_reset_mid_hold();
      obs_t exp_v;
      do_reset();
      pc = 10'h010; mem_load = 1; mem_address = 10'h2C3;
      @(posedge clk);
      #1 mem_load = 0;
      @(posedge clk);
      #3;
      checks++;
      if (d1_bus !== 10'h2C3 || d1_rw !== 1'b1) begin
         errors++; $display("FAIL hold2_bus got %h rw=%b expected 2c3 rw=1", d1_bus, d1_rw);
      end
      rst_n = 1'b0;
      #1;
      exp_v = '0; exp_v.rw = 1'b1;
      checks++;
      if (get_obs(1) !== exp_v) begin
         errors++; $display("FAIL hold_abort got %h expected %h", get_obs(1), exp_v);
      end
      checks++;
      if (d1_stall !== 32'd0 || d1_ops !== 32'd0) begin
         errors++; $display("FAIL hold_abort_perf got %0d %0d expected 0 0", d1_stall, d1_ops);
      end
      @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   task automatic test_random();
      obs_t e, o;
      do_reset();
      model_reset();
      for (int k = 0; k < 600; k++) begin
         if (k % 150 == 149) begin
            do_reset();
            model_reset();
         end
         pc               = 10'($urandom);
         mem_address      = 10'($urandom);
         mem_write_data   = 6'($urandom);
         store_upper      = 1'($urandom);
         mem_store_commit = ($urandom_range(0, 3) == 0);
         mem_load         = ($urandom_range(0, 3) == 0);
         mem_store        = ($urandom_range(0, 5) == 0);
         branch_ex        = ($urandom_range(0, 5) == 0);
         halt_fetch       = ($urandom_range(0, 7) == 0);
         halt_commit      = ($urandom_range(0, 59) == 0);
         @(negedge clk);
         for (int i = 0; i < 2; i++) begin
            e = model_out(i);
            o = get_obs(i);
            checks++;
            if (o !== e) begin
               errors++; $display("FAIL random dut%0d cycle%0d got %h expected %h", i, k, o, e);
            end
         end
`ifdef MEM_SEQ_PERF_EN
         checks++;
         if (d0_stall !== m_stall[0] || d0_ops !== m_ops[0] || d1_stall !== m_stall[1] || d1_ops !== m_ops[1]) begin
            errors++; $display("FAIL random_perf cycle%0d got %0d %0d %0d %0d expected %0d %0d %0d %0d",
                               k, d0_stall, d0_ops, d1_stall, d1_ops, m_stall[0], m_ops[0], m_stall[1], m_ops[1]);
         end
`else
         checks++;
         if (d0_stall !== 32'd0 || d0_ops !== 32'd0 || d1_stall !== 32'd0 || d1_ops !== 32'd0) begin
            errors++; $display("FAIL random_perf_tied cycle%0d got %0d %0d %0d %0d expected 0", k, d0_stall, d0_ops, d1_stall, d1_ops);
         end
`endif
         model_step(0, 0);
         model_step(1, 2);
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      test_reset();
      test_fetch();
      test_store_commit();
      test_commit_vs_load();
      test_load_wait();
      test_halt();
      test_reset_mid_hold();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
